// File: rtl/uart_status_reporter.sv
// uart_status_reporter
//   Shares one UART TX line between byte echo and an ASCII status report.
//   Received 8N1 bytes are echoed. The query byte triggers a snapshot of id and
//   counter, which is sent as "<id>:<counter as 8 hex digits>\n".
// Ports
//   CLK      system clock, rising edge
//   nRST     asynchronous active-low reset
//   UART_RX  serial in, idle high, asynchronous to CLK
//   UART_TX  serial out, idle high
//   id       static board ID
//   counter  free-running counter, sampled when a report starts
//   busy     high from snapshot until the last report stop bit completes
//   rx_err   one-cycle pulse on a framing error
module uart_status_reporter #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  QUERY_BYTE   = 8'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        UART_RX,
    output logic        UART_TX,
    input  logic [3:0]  id,
    input  logic [31:0] counter,
    output logic        busy,
    output logic        rx_err
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // ---------------------------------------------------------------- RX path
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

    rx_state_e     r_rx_state;
    logic          r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift, r_rx_data;
    logic          r_rx_valid, r_rx_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_meta  <= UART_RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                RxIdle: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RxStart;
                        r_rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (r_rx_cnt == HalfLast) begin
                        r_rx_cnt <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!r_rx_sync) begin
                            r_rx_state <= RxData;
                            r_rx_bit   <= '0;
                        end else begin
                            r_rx_state <= RxIdle;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RxData: begin
                    if (r_rx_cnt == BitLast) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RxStop: begin
                    if (r_rx_cnt == BitLast) begin
                        r_rx_cnt <= '0;
                        if (r_rx_sync) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_rx_shift;
                            r_rx_state <= RxIdle;
                        end else begin
                            r_rx_err   <= 1'b1;
                            r_rx_state <= RxWaitHigh;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RxWaitHigh: if (r_rx_sync) r_rx_state <= RxIdle;
                default:    r_rx_state <= RxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- TX engine
    logic          r_tx_out, r_tx_ready;
    logic [8:0]    r_tx_shift;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_nbit;
    logic          w_tx_load;
    logic [7:0]    w_tx_byte;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tx_out   <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
        end else if (w_tx_load) begin
            r_tx_out   <= 1'b0;
            r_tx_shift <= {1'b1, w_tx_byte};
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_ready <= 1'b0;
        end else if (!r_tx_ready) begin
            if (r_tx_cnt == BitLast) begin
                r_tx_cnt <= '0;
                if (r_tx_nbit == 4'd9) begin
                    r_tx_ready <= 1'b1;
                    r_tx_out   <= 1'b1;
                end else begin
                    r_tx_out   <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_nbit  <= r_tx_nbit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    // ---------------------------------------------------------------- controller
    typedef enum logic [2:0] {StIdle, StEcho, StSnap, StSend, StWait} ctl_state_e;

    ctl_state_e  r_state;
    logic        r_echo_pend, r_qpend, r_busy;
    logic [7:0]  r_echo_data;
    logic [3:0]  r_idx, r_snap_id;
    logic [31:0] r_snap_cnt;
    logic [7:0]  w_frame_byte;
    logic        w_is_query, w_echo_take;

    assign w_is_query  = (r_rx_data == QUERY_BYTE);
    assign w_echo_take = (r_state == StEcho) && r_tx_ready;

    always_comb begin
        w_frame_byte = 8'h0A;
        case (r_idx)
            4'd0:    w_frame_byte = hex_ascii(r_snap_id);
            4'd1:    w_frame_byte = 8'h3A;
            4'd2:    w_frame_byte = hex_ascii(r_snap_cnt[31:28]);
            4'd3:    w_frame_byte = hex_ascii(r_snap_cnt[27:24]);
            4'd4:    w_frame_byte = hex_ascii(r_snap_cnt[23:20]);
            4'd5:    w_frame_byte = hex_ascii(r_snap_cnt[19:16]);
            4'd6:    w_frame_byte = hex_ascii(r_snap_cnt[15:12]);
            4'd7:    w_frame_byte = hex_ascii(r_snap_cnt[11:8]);
            4'd8:    w_frame_byte = hex_ascii(r_snap_cnt[7:4]);
            4'd9:    w_frame_byte = hex_ascii(r_snap_cnt[3:0]);
            default: w_frame_byte = 8'h0A;
        endcase
    end

    // SNAP loads byte 0 straight from id (static) so the first start bit
    // follows the query as closely as an echo would.
    always_comb begin
        w_tx_load = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            StEcho: begin w_tx_load = r_tx_ready; w_tx_byte = r_echo_data;   end
            StSnap: begin w_tx_load = r_tx_ready; w_tx_byte = hex_ascii(id); end
            StSend: begin w_tx_load = r_tx_ready; w_tx_byte = w_frame_byte;  end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= StIdle;
            r_echo_pend <= 1'b0;
            r_echo_data <= '0;
            r_qpend     <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_snap_id   <= '0;
            r_snap_cnt  <= '0;
        end else begin
            if (w_echo_take) r_echo_pend <= 1'b0;
            // Last received byte wins the single echo slot.
            if (r_rx_valid && !w_is_query) begin
                r_echo_pend <= 1'b1;
                r_echo_data <= r_rx_data;
            end
            // Queries during a report are dropped.
            if (r_rx_valid && w_is_query && !r_busy) r_qpend <= 1'b1;

            case (r_state)
                StIdle: begin
                    if (r_qpend || (r_rx_valid && w_is_query)) begin
                        r_state <= StSnap;
                        r_busy  <= 1'b1;
                    end else if (r_echo_pend || (r_rx_valid && !w_is_query)) begin
                        r_state <= StEcho;
                    end
                end
                StEcho: if (r_tx_ready) r_state <= StIdle;
                StSnap: begin
                    r_snap_id  <= id;
                    r_snap_cnt <= counter;
                    r_idx      <= '0;
                    r_qpend    <= 1'b0;
                    r_state    <= r_tx_ready ? StWait : StSend;
                end
                StSend: if (r_tx_ready) r_state <= StWait;
                StWait: begin
                    if (r_tx_ready) begin
                        if (r_idx == 4'd10) begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= StSend;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign UART_TX = r_tx_out;
    assign busy    = r_busy;
    assign rx_err  = r_rx_err;

endmodule

// File: doc/uart_status_reporter.md
# uart_status_reporter

UART command responder that shares the board's single UART TX line between byte echo and a status report. It receives 8N1 bytes on UART_RX and echoes ordinary bytes back. On the query byte 0x3F ('?') it snapshots the board ID and the free-running counter, then sends them as an ASCII line. It sits between the board pins and the counter/ID registers, replacing the direct RX-to-TX wire.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- QUERY_BYTE, 8'h3F: byte value that triggers a report.

- CLK  input  1  system clock, all logic on rising edge.
- nRST  input  1  asynchronous active-low reset, async assert; the integrator supplies synchronous deassert.
- UART_RX  input  1  serial in, idle high, asynchronous to CLK.
- UART_TX  output  1  serial out, idle high.
- id  input  4  board ID, treated as static.
- counter  input  32  free-running counter, sampled on query.
- busy  output  1  high while a report frame is in progress (snapshot through last stop bit).
- rx_err  output  1  one-cycle pulse on a framing error (stop bit sampled 0).

## Operation
- RX path:
  - 2-FF synchronizer on UART_RX.
  - Start detected on a synchronized falling edge while RX is idle.
  - Start bit re-checked at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle.
  - Data bits are sampled every CLKS_PER_BIT from the mid-start point, LSB first, then the stop bit.
  - Stop = 0: pulse rx_err, discard the byte, then wait for the line to read high before arming again.
  - A good stop bit produces a one-cycle rx_valid with rx_data (internal).
- TX engine: 8N1, LSB first. Internal load/ready handshake: a byte is accepted only when tx_ready = 1, and tx_ready drops on the load cycle.
- Controller FSM states: IDLE, ECHO, SNAP, SEND, WAIT.
  - IDLE, with rx_valid and rx_data == QUERY_BYTE → SNAP.
  - IDLE, with pending echo byte or rx_valid for another byte → ECHO. Load that byte when tx_ready; back to IDLE after the load.
  - SNAP: latch id and counter into a 36-bit snapshot in one cycle, set busy, clear the index to 0, then go to SEND.
  - SEND: when tx_ready, load frame byte[index] and go to WAIT.
  - WAIT: wait for tx_ready. If index == 10, clear busy and go to IDLE. Otherwise increment index and go to SEND.
- Report frame, 11 bytes in this order:
  - hex(id);
  - ':' (0x3A);
  - counter[31:28] down to counter[3:0] as 8 hex digits;
  - '\n' (0x0A).
  - Hex digits are uppercase ASCII: 0-9 map to 0x30-0x39, A-F to 0x41-0x46.
- Arbitration:
  - A report in progress owns TX.
  - A non-query byte received while busy, or while an echo is still shifting, goes into a 1-entry echo buffer. A later byte overwrites the buffer (last wins).
  - A query received while busy is dropped, with no second report.
  - The buffered echo is sent once the report finishes.
  - If an echo is pending when a query arrives, the query is honoured first and the echo follows it.
- Reset mid-operation: the frame is abandoned immediately and the line returns to idle high. No partial byte is sent after release.

## Timing
- Reset values:
  - outputs: UART_TX = 1, busy = 0, rx_err = 0;
  - internal: FSM = IDLE, echo buffer empty, index = 0, tx_ready = 1.
- Synchronizer latency is 2 cycles.
- rx_valid asserts at the mid-point of the stop bit, i.e. about 9.5 bit times after the start edge plus 2 cycles.
- Query to frame: busy rises 1 cycle after rx_valid (SNAP). The first start bit begins 2 cycles after rx_valid.
- The snapshot value is the counter as of the SNAP cycle.
- Each TX byte takes exactly 10 × CLKS_PER_BIT cycles.
- Consecutive report bytes are separated by at most 2 idle cycles.
- busy falls 1 cycle after the last stop bit completes.
- Echo latency: the start bit begins 2 cycles after rx_valid when TX is idle.
- Counter arithmetic: the snapshot is a plain latch. Wrap-around of the source counter needs no special handling; 0xFFFFFFFF prints as "FFFFFFFF".

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset: hold nRST = 0 for 5 cycles → UART_TX = 1, busy = 0, rx_err = 0. Release, with no RX activity for 200 cycles → TX stays 1.
- Echo: send 0x55 → TX emits 0x55 framed 8N1, and its start bit begins 2 cycles after rx_valid.
- Report: id = 4'hA, counter = 32'h0123ABCD at SNAP → TX emits "A:0123ABCD\n" (11 bytes), busy is high for the whole frame, and wrap value 0xFFFFFFFF gives "FFFFFFFF".
- Collision: send '?', then 0x41 and 0x42 during the report → exactly one report followed by a single echo 0x42. A second '?' sent mid-report produces no extra frame.
- Framing error: send a byte with stop bit = 0 → rx_err pulses for 1 cycle, nothing is echoed, and the next good byte 0x33 is echoed correctly.
- Reset mid-frame: assert nRST during byte 5 of a report → UART_TX = 1 and busy = 0 immediately. After release, a new '?' gives a complete 11-byte frame.
